fifo_rr_sched: RTL and testbench

FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

---
 rtl/fifo_rr_sched.sv | 90 +++++++++
 tb/tb_fifo_rr_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_sched.sv
// fifo_rr_sched: round-robin scheduler that drains first-word-fall-through queues
// in bursts of up to BURST words into a single registered output stage.
module fifo_rr_sched #(
    parameter int NUM_Q  = 4,
    parameter int DWIDTH = 32,
    parameter int BURST  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_Q*DWIDTH-1:0]  q_rd_data,
    input  logic [NUM_Q-1:0]         q_rd_empty,
    output logic [NUM_Q-1:0]         q_rd_en,
    input  logic [NUM_Q-1:0]         q_enable,
    output logic [DWIDTH-1:0]        out_data,
    output logic [$clog2(NUM_Q)-1:0] out_qid,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int QW = $clog2(NUM_Q);
    localparam int CW = $clog2(BURST) + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [QW-1:0]   r_g;
    logic [QW-1:0]   r_last;
    logic [QW-1:0]   w_sel;
    logic [CW-1:0]   r_cnt;
    logic [NUM_Q-1:0] w_elig;
    logic            w_hit;
    logic            w_ok;
    logic            w_pop;
    logic            w_end;

    assign w_elig  = q_enable & ~q_rd_empty;
    assign w_ok    = (r_state == ACTIVE) && w_elig[r_g];
    // rst gates the pop so no word leaves a queue during a reset cycle
    assign w_pop   = w_ok && (!out_valid || out_ready) && !rst;
    assign w_end   = !w_ok || (w_pop && r_cnt == CW'(BURST - 1));
    assign q_rd_en = w_pop ? (NUM_Q'(1) << r_g) : '0;
    assign busy    = (r_state == ACTIVE);

    // descending scan so the nearest queue after r_last is the one that sticks
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int k = NUM_Q; k >= 1; k--) begin
            if (w_elig[(int'(r_last) + k) % NUM_Q]) begin
                w_hit = 1'b1;
                w_sel = QW'((int'(r_last) + k) % NUM_Q);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == IDLE) ? (w_hit ? ACTIVE : IDLE) : (w_end ? IDLE : ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= QW'(NUM_Q - 1);
            r_g       <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_qid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_hit) begin
                r_g   <= w_sel;
                r_cnt <= '0;
            end
            if (w_pop)
                r_cnt <= r_cnt + 1'b1;
            if (r_state == ACTIVE && w_end)
                r_last <= r_g;
            if (w_pop) begin
                out_data  <= q_rd_data[r_g*DWIDTH +: DWIDTH];
                out_qid   <= r_g;
                out_valid <= 1'b1;
            end else if (!out_valid || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fifo_rr_sched.sv
// tb_fifo_rr_sched: directed bench with FWFT queue models; a 4-queue/BURST=8 instance
// and a 3-queue/BURST=1 instance share the clock.
module tb_fifo_rr_sched;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         rst3 = 1'b1;
    logic [127:0] q_rd_data;
    logic [3:0]   q_rd_empty;
    logic [3:0]   q_rd_en;
    logic [3:0]   q_enable = 4'hF;
    logic [31:0]  out_data;
    logic [1:0]   out_qid;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         busy;
    logic [23:0]  q_rd_data3;
    logic [2:0]   q_rd_en3;
    logic [7:0]   out_data3;
    logic [1:0]   out_qid3;
    logic         out_valid3;
    logic         busy3;

    logic [31:0] mem [4][32];
    int rp [4];
    int wp [4];
    int cnt3 [3];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]  qid;
        logic [31:0] d;
    } rec_t;
    rec_t got[$];
    rec_t got3[$];

    always_comb begin
        q_rd_data  = '0;
        q_rd_empty = '0;
        q_rd_data3 = '0;
        for (int i = 0; i < 4; i++) begin
            q_rd_data[i*32 +: 32] = mem[i][rp[i] % 32];
            q_rd_empty[i]         = (rp[i] == wp[i]);
        end
        for (int i = 0; i < 3; i++)
            q_rd_data3[i*8 +: 8] = 8'(i * 64 + cnt3[i]);
    end

    fifo_rr_sched #(.NUM_Q(4), .DWIDTH(32), .BURST(8)) u_dut (
        .clk(clk), .rst(rst), .q_rd_data(q_rd_data), .q_rd_empty(q_rd_empty),
        .q_rd_en(q_rd_en), .q_enable(q_enable), .out_data(out_data), .out_qid(out_qid),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    fifo_rr_sched #(.NUM_Q(3), .DWIDTH(8), .BURST(1)) u_dut3 (
        .clk(clk), .rst(rst3), .q_rd_data(q_rd_data3), .q_rd_empty(3'b000),
        .q_rd_en(q_rd_en3), .q_enable(3'b111), .out_data(out_data3), .out_qid(out_qid3),
        .out_valid(out_valid3), .out_ready(1'b1), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int q, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            mem[q][wp[q] % 32] = base + 32'(k);
            wp[q]++;
        end
    endtask

    // one clock: record accepted words and pops, then land #1 after the edge
    task automatic step();
        logic [3:0] en;
        logic [2:0] en3;
        @(negedge clk);
        en  = q_rd_en;
        en3 = q_rd_en3;
        if (out_valid && out_ready) got.push_back('{out_qid, out_data});
        if (out_valid3) got3.push_back('{out_qid3, {24'b0, out_data3}});
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (en[i]) rp[i]++;
        for (int i = 0; i < 3; i++) if (en3[i]) cnt3[i]++;
        chk("onehot0_q4", 64'($onehot0(q_rd_en)), 64'd1);
        chk("onehot0_q3", 64'($onehot0(q_rd_en3)), 64'd1);
    endtask

    task automatic start();
        rst = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            rp[i] = 0;
            wp[i] = 0;
        end
        got.delete();
    endtask

    task automatic release_rst();
        step();
        chk("rst_en", q_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_qid", out_qid, 0);
        rst = 1'b0;
    endtask

    initial begin
        int e;
        // long queue: bursts of 8 separated by one arbitration cycle
        start();
        push(0, 20, 32'h100);
        q_enable  = 4'hF;
        out_ready = 1'b1;
        release_rst();
        for (int n = 1; n <= 25; n++) begin
            step();
            e = (n >= 2 && n <= 9) ? n - 2 : (n >= 11 && n <= 18) ? n - 3 :
                (n >= 20 && n <= 23) ? n - 4 : -1;
            chk("A_valid", out_valid, 64'(e >= 0));
            if (e >= 0) begin
                chk("A_data", out_data, 32'h100 + 32'(e));
                chk("A_qid", out_qid, 0);
            end
            if (n == 9) chk("A_busy_gap", busy, 0);
            if (n == 10) chk("A_busy_regrant", busy, 1);
        end

        // four short queues served in index order
        start();
        for (int q = 0; q < 4; q++) push(q, 3, 32'h200 + 32'(q * 16));
        release_rst();
        for (int n = 0; n < 80 && got.size() < 12; n++) step();
        chk("B_count", 64'(got.size()), 12);
        for (int k = 0; k < 12 && k < got.size(); k++) begin
            chk("B_qid", got[k].qid, 64'(k / 3));
            chk("B_data", got[k].d, 32'h200 + 32'((k / 3) * 16 + k % 3));
        end

        // backpressure on q1 holds the word and the grant
        start();
        push(1, 6, 32'h300);
        release_rst();
        step();
        step();
        chk("C_first_valid", out_valid, 1);
        chk("C_first_data", out_data, 32'h300);
        chk("C_first_qid", out_qid, 1);
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("C_hold_valid", out_valid, 1);
            chk("C_hold_data", out_data, 32'h300);
            chk("C_hold_en", q_rd_en, 0);
            chk("C_hold_busy", busy, 1);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 40 && got.size() < 6; n++) step();
        chk("C_count", 64'(got.size()), 6);
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            chk("C_qid", got[k].qid, 1);
            chk("C_data", got[k].d, 32'h300 + 32'(k));
        end

        // disabled q2 is skipped until re-enabled
        start();
        q_enable = 4'b1011;
        push(2, 3, 32'h400);
        push(3, 3, 32'h500);
        release_rst();
        for (int n = 0; n < 20; n++) step();
        chk("D_q2_untouched", 64'(rp[2]), 0);
        chk("D_count", 64'(got.size()), 3);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            chk("D_qid", got[k].qid, 3);
            chk("D_data", got[k].d, 32'h500 + 32'(k));
        end
        got.delete();
        q_enable = 4'hF;
        for (int n = 0; n < 40 && got.size() < 3; n++) step();
        chk("D_reen_count", 64'(got.size()), 3);
        for (int k = 0; k < 3 && k < got.size(); k++) begin
            chk("D_reen_qid", got[k].qid, 2);
            chk("D_reen_data", got[k].d, 32'h400 + 32'(k));
        end

        // reset mid-burst on q1: held word dropped, search restarts at queue 0
        start();
        push(1, 10, 32'h600);
        push(2, 5, 32'h700);
        release_rst();
        for (int n = 0; n < 4; n++) step();
        chk("E_pre_data", out_data, 32'h602);
        rst = 1'b1;
        #2;
        chk("E_en_in_rst", q_rd_en, 0);
        step();
        rst = 1'b0;
        chk("E_valid_after", out_valid, 0);
        chk("E_busy_after", busy, 0);
        chk("E_en_after", q_rd_en, 0);
        step();
        chk("E_regrant_busy", busy, 1);
        step();
        chk("E_regrant_valid", out_valid, 1);
        chk("E_regrant_qid", out_qid, 1);
        chk("E_regrant_data", out_data, 32'h603);

        // three always-full queues with single-word grants
        rst3 = 1'b0;
        got3.delete();
        for (int n = 0; n < 40 && got3.size() < 6; n++) step();
        chk("F_count", 64'(got3.size() >= 6), 1);
        for (int k = 0; k < 6 && k < got3.size(); k++) begin
            chk("F_qid", got3[k].qid, 64'(k % 3));
            chk("F_data", got3[k].d, 32'((k % 3) * 64 + k / 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
